gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
//   Register-mapped controller for the GPIO_WIDTH-bit IOBUF pad bank. Holds output-data
//   and direction registers that drive the pad bank's write/tristate inputs, synchronises
//   the pad read-back, detects per-pin edges and raises a level interrupt. Sits between
//   the system register bus and the pad bank instance.
// PARAMETERS
//   GPIO_WIDTH  16  pins controlled; also the register data width
//   SYNC_STAGES 2   input synchroniser depth (>=2)
// PORTS
//   clk          in   1           system clock; all logic is on the rising edge
//   rst          in   1           synchronous, active-high reset
//   wr_en        in   1           register write strobe, one cycle per write
//   rd_en        in   1           register read strobe, one cycle per read
//   addr         in   3           register address
//   wr_data      in   GPIO_WIDTH  write data
//   rd_data      out  GPIO_WIDTH  read data, valid when rd_valid=1
//   rd_valid     out  1           read response strobe
//   irq          out  1           level interrupt, |(IRQ_STAT & IRQ_EN)
//   gpio_write   out  GPIO_WIDTH  to pad bank I (output data)
//   gpio_status  out  GPIO_WIDTH  to pad bank T (1 = pin tristated / input)
//   gpio_read    in   GPIO_WIDTH  from pad bank O (asynchronous pad value)
// BEHAVIOUR
//   Register map (addr): 0 OUT RW | 1 DIR RW (1=output) | 2 IN RO (synchronised pads)
//     | 3 IRQ_EN RW | 4 IRQ_STAT R/W1C | 5 EDGE_SEL RW (1=rising, 0=falling) | 6,7 unmapped.
//   Reset: OUT=0, DIR=0, IRQ_EN=0, IRQ_STAT=0, EDGE_SEL=0, sync flops=0, rd_data=0,
//     rd_valid=0, irq=0, gpio_write=0, gpio_status=all 1s (every pin an input).
//   gpio_write = OUT; gpio_status = ~DIR; both registered, change 1 cycle after wr_en.
//   Writes: take effect on the clock edge where wr_en=1. Writes to IN or 6/7 ignored.
//     IRQ_STAT write: bits with wr_data=1 cleared, 0 bits unchanged.
//   Reads: rd_en at cycle N -> rd_valid=1 with rd_data at N+1, single-cycle pulse.
//     rd_data holds value until next read. Unmapped read returns 0 with rd_valid=1.
//     rd_en and wr_en same cycle, same addr: read returns pre-write value.
//   Input path: gpio_read -> SYNC_STAGES flop chain -> IN; pad change visible in IN
//     SYNC_STAGES cycles later. Pins configured as outputs still read back pad value.
//   Edge detect: compares IN with its 1-cycle delayed copy, per bit; rising when
//     prev=0,cur=1; falling when prev=1,cur=0; EDGE_SEL selects which sets IRQ_STAT.
//     Detection active on all pins regardless of DIR; IRQ_EN only gates irq, not STAT.
//   Arm counter: after rst deassertion, edge detection disabled for SYNC_STAGES+1
//     cycles (pipeline fill); states ARMING -> ARMED; rst mid-operation returns to
//     ARMING, clears all registers and any pending read response.
//   Simultaneous W1C and new edge on same bit: edge wins, bit remains 1.
//   irq registered: asserts 1 cycle after IRQ_STAT/IRQ_EN change making the AND nonzero.
//   No backpressure: back-to-back rd_en every cycle yields rd_valid every cycle.
// TESTING
//   1 Reset -> gpio_status=16'hFFFF, gpio_write=0, irq=0, rd_valid=0; read DIR -> 0.
//   2 Write DIR=16'h00FF, OUT=16'h00A5 -> next cycle gpio_status=16'hFF00,
//     gpio_write=16'h00A5; read-back OUT returns 16'h00A5 one cycle after rd_en.
//   3 EDGE_SEL=1, IRQ_EN=16'h0001, drive gpio_read[0] 0->1 -> IRQ_STAT[0]=1 and irq=1
//     within SYNC_STAGES+2 cycles; W1C 16'h0001 -> irq=0 next cycle.
//   4 W1C IRQ_STAT[3] in same cycle a rising edge on synced bit 3 -> IRQ_STAT[3] stays 1.
//   5 gpio_read=16'hFFFF held through rst release -> no IRQ_STAT bits set (arm window);
//     read of addr 6 -> rd_data=0, rd_valid=1.
//   6 Assert rst mid-sequence after OUT=16'h1234, pending read -> rd_valid=0,
//     gpio_write=0, gpio_status=16'hFFFF next cycle.

Source files
------------

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: output/direction registers for the pad bank, synchronised
// read-back, per-pin edge detection into a W1C status register and a level interrupt.
module gpio_ctrl #(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [2:0]            addr,
  input  logic [GPIO_WIDTH-1:0] wr_data,
  output logic [GPIO_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  irq,
  output logic [GPIO_WIDTH-1:0] gpio_write,
  output logic [GPIO_WIDTH-1:0] gpio_status,
  input  logic [GPIO_WIDTH-1:0] gpio_read
);

  localparam logic [2:0] AddrOut     = 3'd0;
  localparam logic [2:0] AddrDir     = 3'd1;
  localparam logic [2:0] AddrIn      = 3'd2;
  localparam logic [2:0] AddrIrqEn   = 3'd3;
  localparam logic [2:0] AddrIrqStat = 3'd4;
  localparam logic [2:0] AddrEdgeSel = 3'd5;

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    StArming,
    StArmed
  } arm_state_e;

  // Register file
  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [GPIO_WIDTH-1:0] edge_sel_q, edge_sel_d;

  // Input path
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] in_val;
  logic [GPIO_WIDTH-1:0] in_prev_q;
  logic [GPIO_WIDTH-1:0] rise, fall, edge_hit;

  // Read response and outputs
  logic [GPIO_WIDTH-1:0] rd_mux;
  logic [GPIO_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  irq_q;
  logic [GPIO_WIDTH-1:0] gpio_write_q;
  logic [GPIO_WIDTH-1:0] gpio_status_q;

  // Arm sequencing
  arm_state_e            state_q, state_d;
  logic [CntW-1:0]       arm_cnt_q, arm_cnt_d;
  logic                  armed;

  assign in_val = sync_q[SYNC_STAGES-1];

  // Edge detection is held off until the synchroniser and the delayed copy hold real pad data.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    armed     = 1'b0;
    case (state_q)
      StArming: begin
        if (arm_cnt_q == CntW'(SYNC_STAGES)) begin
          state_d = StArmed;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      StArmed: begin
        armed = 1'b1;
      end
      default: begin
        state_d = StArming;
      end
    endcase
  end

  always_comb begin
    rise     = in_val & ~in_prev_q;
    fall     = ~in_val & in_prev_q;
    edge_hit = '0;
    if (armed) begin
      edge_hit = (rise & edge_sel_q) | (fall & ~edge_sel_q);
    end
  end

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    irq_stat_d = irq_stat_q;
    if (wr_en) begin
      case (addr)
        AddrOut:     out_d      = wr_data;
        AddrDir:     dir_d      = wr_data;
        AddrIrqEn:   irq_en_d   = wr_data;
        AddrIrqStat: irq_stat_d = irq_stat_q & ~wr_data;
        AddrEdgeSel: edge_sel_d = wr_data;
        default:     ;
      endcase
    end
    // A new edge overrides a simultaneous clear of the same bit.
    irq_stat_d = irq_stat_d | edge_hit;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      AddrOut:     rd_mux = out_q;
      AddrDir:     rd_mux = dir_q;
      AddrIn:      rd_mux = in_val;
      AddrIrqEn:   rd_mux = irq_en_q;
      AddrIrqStat: rd_mux = irq_stat_q;
      AddrEdgeSel: rd_mux = edge_sel_q;
      default:     rd_mux = '0;
    endcase
    rd_data_d = rd_en ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q         <= '0;
      dir_q         <= '0;
      irq_en_q      <= '0;
      irq_stat_q    <= '0;
      edge_sel_q    <= '0;
      sync_q        <= '0;
      in_prev_q     <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      irq_q         <= 1'b0;
      gpio_write_q  <= '0;
      gpio_status_q <= '1;
      state_q       <= StArming;
      arm_cnt_q     <= '0;
    end else begin
      out_q         <= out_d;
      dir_q         <= dir_d;
      irq_en_q      <= irq_en_d;
      irq_stat_q    <= irq_stat_d;
      edge_sel_q    <= edge_sel_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], gpio_read};
      in_prev_q     <= in_val;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en;
      irq_q         <= |(irq_stat_q & irq_en_q);
      gpio_write_q  <= out_d;
      gpio_status_q <= ~dir_d;
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign irq         = irq_q;
  assign gpio_write  = gpio_write_q;
  assign gpio_status = gpio_status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized traffic compared
// cycle by cycle against a register-level reference model.
module tb_gpio_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [2:0]   addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         irq;
  logic [W-1:0] gpio_write;
  logic [W-1:0] gpio_status;
  logic [W-1:0] gpio_read;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .irq         (irq),
    .gpio_write  (gpio_write),
    .gpio_status (gpio_status),
    .gpio_read   (gpio_read)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register contents, pad history as a delay queue, edge count since reset.
  logic [W-1:0] m_out, m_dir, m_en, m_stat, m_sel, m_in, m_prev, m_rd_data;
  logic         m_rd_valid, m_irq;
  int           m_edges;
  logic [W-1:0] m_padq[$];

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_sel = '0;
    m_in = '0; m_prev = '0; m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
    m_edges = 0;
    m_padq = {};
    for (int i = 0; i < int'(S); i++) m_padq.push_back('0);
  endtask

  task automatic model_edge(input logic r, input logic we, input logic re, input logic [2:0] a,
                            input logic [W-1:0] wd, input logic [W-1:0] pads);
    logic [W-1:0] rv, hit, clr;
    if (r) begin
      model_reset();
      return;
    end
    m_edges++;
    case (a)
      3'd0:    rv = m_out;
      3'd1:    rv = m_dir;
      3'd2:    rv = m_in;
      3'd3:    rv = m_en;
      3'd4:    rv = m_stat;
      3'd5:    rv = m_sel;
      default: rv = '0;
    endcase
    if (re) m_rd_data = rv;
    m_rd_valid = re;
    m_irq = |(m_stat & m_en);
    hit = '0;
    if (m_edges >= int'(S) + 2) begin
      for (int i = 0; i < int'(W); i++) begin
        if (m_sel[i] && !m_prev[i] && m_in[i]) hit[i] = 1'b1;
        if (!m_sel[i] && m_prev[i] && !m_in[i]) hit[i] = 1'b1;
      end
    end
    clr = (we && a == 3'd4) ? wd : '0;
    if (we) begin
      case (a)
        3'd0:    m_out = wd;
        3'd1:    m_dir = wd;
        3'd3:    m_en  = wd;
        3'd5:    m_sel = wd;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | hit;
    m_prev = m_in;
    m_padq.push_back(pads);
    void'(m_padq.pop_front());
    m_in = m_padq[0];
  endtask

  task automatic step(input logic r, input logic we, input logic re, input logic [2:0] a,
                      input logic [W-1:0] wd, input logic [W-1:0] pads);
    rst = r; wr_en = we; rd_en = re; addr = a; wr_data = wd; gpio_read = pads;
    @(posedge clk);
    model_edge(r, we, re, a, wd, pads);
    #1;
    check_eq("gpio_write", gpio_write, m_out);
    check_eq("gpio_status", gpio_status, ~m_dir);
    check_eq("irq", W'(irq), W'(m_irq));
    check_eq("rd_valid", W'(rd_valid), W'(m_rd_valid));
    check_eq("rd_data", rd_data, m_rd_data);
  endtask

  logic [W-1:0] pads;
  logic         seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pads = '0;
    model_reset();
    // Reset state
    step(1, 0, 0, 0, 0, pads);
    step(1, 0, 0, 0, 0, pads);
    check_eq("t1_status", gpio_status, 16'hFFFF);
    check_eq("t1_write", gpio_write, 16'h0000);
    check_eq("t1_irq", W'(irq), '0);
    check_eq("t1_rd_valid", W'(rd_valid), '0);
    step(0, 0, 0, 0, 0, pads);
    step(0, 0, 1, 3'd1, 0, pads);
    check_eq("t1_dir_valid", W'(rd_valid), W'(1'b1));
    check_eq("t1_dir_data", rd_data, 16'h0000);

    // Direction and output data
    step(0, 1, 0, 3'd1, 16'h00FF, pads);
    step(0, 1, 0, 3'd0, 16'h00A5, pads);
    check_eq("t2_status", gpio_status, 16'hFF00);
    check_eq("t2_write", gpio_write, 16'h00A5);
    step(0, 0, 1, 3'd0, 0, pads);
    check_eq("t2_rd_valid", W'(rd_valid), W'(1'b1));
    check_eq("t2_rd_data", rd_data, 16'h00A5);
    step(0, 0, 0, 0, 0, pads);
    check_eq("t2_pulse", W'(rd_valid), '0);
    check_eq("t2_hold", rd_data, 16'h00A5);

    // Rising edge on pin 0 raises irq within S+2 cycles, W1C drops it
    step(0, 1, 0, 3'd5, 16'h0001, pads);
    step(0, 1, 0, 3'd3, 16'h0001, pads);
    pads[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < int'(S) + 2; k++) begin
      step(0, 0, 0, 0, 0, pads);
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t3_irq_seen", W'(seen), W'(1'b1));
    step(0, 0, 1, 3'd4, 0, pads);
    check_eq("t3_stat", rd_data & 16'h0001, 16'h0001);
    step(0, 1, 0, 3'd4, 16'h0001, pads);
    step(0, 0, 0, 0, 0, pads);
    check_eq("t3_irq_clear", W'(irq), '0);

    // Edge beats a simultaneous W1C on bit 3
    step(0, 1, 0, 3'd5, 16'h0009, pads);
    pads[3] = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, pads);
    pads[3] = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, pads);
    step(0, 0, 1, 3'd4, 0, pads);
    check_eq("t4_pre", rd_data & 16'h0008, 16'h0008);
    pads[3] = 1'b1;
    step(0, 0, 0, 0, 0, pads);
    step(0, 0, 0, 0, 0, pads);
    step(0, 1, 0, 3'd4, 16'h0008, pads);
    step(0, 0, 1, 3'd4, 0, pads);
    check_eq("t4_stat3", rd_data & 16'h0008, 16'h0008);

    // Pads high through reset release: arm window suppresses the fill transition
    pads = 16'hFFFF;
    step(1, 0, 0, 0, 0, pads);
    step(1, 0, 0, 0, 0, pads);
    repeat (6) step(0, 0, 0, 0, 0, pads);
    step(0, 0, 1, 3'd4, 0, pads);
    check_eq("t5_stat", rd_data, 16'h0000);
    step(0, 0, 1, 3'd2, 0, pads);
    check_eq("t5_in", rd_data, 16'hFFFF);
    step(0, 0, 1, 3'd6, 0, pads);
    check_eq("t5_unmapped_valid", W'(rd_valid), W'(1'b1));
    check_eq("t5_unmapped_data", rd_data, 16'h0000);

    // Reset mid-sequence kills a pending read response
    step(0, 1, 0, 3'd0, 16'h1234, pads);
    step(0, 1, 0, 3'd1, 16'hFFFF, pads);
    check_eq("t6_write", gpio_write, 16'h1234);
    step(1, 0, 1, 3'd0, 0, pads);
    check_eq("t6_rd_valid", W'(rd_valid), '0);
    check_eq("t6_write_rst", gpio_write, 16'h0000);
    check_eq("t6_status_rst", gpio_status, 16'hFFFF);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic         r, we, re;
      logic [2:0]   a;
      logic [W-1:0] wd;
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 2) == 0);
      re = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      wd = W'($urandom);
      pads = pads ^ W'($urandom & $urandom & $urandom);
      step(r, we, re, a, wd, pads);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
